// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared bfloat16 types, constants and classification helpers
package bf16_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [15:0] BF16_QNAN     = 16'h7FC0;
  localparam logic [7:0]  BF16_EXP_MAX  = 8'hFF;

  function automatic logic bf16_is_nan(input bf16_t v);
    return (v.e == BF16_EXP_MAX) && (v.m != 7'h00);
  endfunction

  function automatic logic bf16_is_inf(input bf16_t v);
    return (v.e == BF16_EXP_MAX) && (v.m == 7'h00);
  endfunction

endpackage

// File: rtl/bf16_add.sv
// rtl/bf16_add.sv - combinational bfloat16 adder, round-to-nearest-even, subnormals kept
module bf16_add
  import bf16_pkg::*;
(
  input  bf16_t a_i,
  input  bf16_t b_i,
  output bf16_t y_o
);

  // Position of the leading one in an 11-bit word, 11 when the word is zero.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  bf16_t       big, sml;
  logic [7:0]  eb_big, eb_sml, d, limit, sh;
  logic [7:0]  sig_big, sig_sml;
  logic [21:0] wide;
  logic [10:0] shifted, a11, b11, n11;
  logic        lost, eff_sub, rnd;
  logic [11:0] sum12;
  logic [3:0]  lz;
  logic [9:0]  ex;
  logic [8:0]  sig9;
  logic [7:0]  sig;

  // Align the smaller operand with guard/round/sticky bits, add, normalise and round.
  always_comb begin
    y_o     = bf16_t'(BF16_POS_ZERO);
    big     = a_i;
    sml     = b_i;
    if ({b_i.e, b_i.m} > {a_i.e, a_i.m}) begin
      big = b_i;
      sml = a_i;
    end
    // Subnormals share the exponent of the smallest normal but have no hidden one.
    eb_big  = (big.e == 8'h00) ? 8'd1 : big.e;
    eb_sml  = (sml.e == 8'h00) ? 8'd1 : sml.e;
    sig_big = {big.e != 8'h00, big.m};
    sig_sml = {sml.e != 8'h00, sml.m};
    d       = eb_big - eb_sml;
    wide    = {sig_sml, 14'b0} >> d;
    shifted = wide[21:11];
    lost    = |wide[10:0];
    if (d >= 8'd22) begin
      shifted = 11'h000;
      lost    = |sig_sml;
    end
    a11     = {sig_big, 3'b000};
    b11     = {shifted[10:1], shifted[0] | lost};
    eff_sub = big.s ^ sml.s;
    sum12   = eff_sub ? ({1'b0, a11} - {1'b0, b11}) : ({1'b0, a11} + {1'b0, b11});
    ex      = {2'b00, eb_big};
    lz      = lzc11(sum12[10:0]);
    limit   = eb_big - 8'd1;
    sh      = 8'h00;
    n11     = sum12[10:0];
    if (sum12[11]) begin
      n11 = {sum12[11:2], sum12[1] | sum12[0]};
      ex  = ex + 10'd1;
    end else begin
      // Never normalise below the smallest exponent; the result then stays subnormal.
      sh  = (8'(lz) < limit) ? 8'(lz) : limit;
      n11 = sum12[10:0] << sh;
      ex  = ex - {2'b00, sh};
    end
    rnd  = n11[2] & (n11[1] | n11[0] | n11[3]);
    sig9 = {1'b0, n11[10:3]} + {8'h00, rnd};
    sig  = sig9[7:0];
    if (sig9[8]) begin
      sig = 8'h80;
      ex  = ex + 10'd1;
    end

    if (bf16_is_nan(a_i) || bf16_is_nan(b_i) ||
        (bf16_is_inf(a_i) && bf16_is_inf(b_i) && (a_i.s != b_i.s))) begin
      y_o = bf16_t'(BF16_QNAN);
    end else if (bf16_is_inf(a_i)) begin
      y_o = a_i;
    end else if (bf16_is_inf(b_i)) begin
      y_o = b_i;
    end else if (sum12 == 12'h000) begin
      // Exact cancellation gives +0; only (-0)+(-0) keeps the negative sign.
      y_o = '{s: big.s & sml.s, e: 8'h00, m: 7'h00};
    end else if (ex >= 10'd255) begin
      y_o = '{s: big.s, e: BF16_EXP_MAX, m: 7'h00};
    end else begin
      y_o = '{s: big.s, e: (sig[7] ? ex[7:0] : 8'h00), m: sig[6:0]};
    end
  end

endmodule

// File: rtl/bf16_acc.sv
// rtl/bf16_acc.sv - streaming bfloat16 frame accumulator; option macro BF16_ACC_NAN_STICKY_EN
module bf16_acc
  import bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_last_i,
  input  logic             s_i,
  input  logic [7:0]       e_i,
  input  logic [6:0]       m_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             s_o,
  output logic [7:0]       e_o,
  output logic [6:0]       m_o,
  output logic [CNT_W-1:0] cnt_o
);

  bf16_t            x_q, x_d;
  logic             x_last_q, x_last_d;
  logic             x_vld_q, x_vld_d;
  bf16_t            acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  bf16_t            res_q, res_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             rdy_en_q, rdy_en_d;
`ifdef BF16_ACC_NAN_STICKY_EN
  logic             nan_q, nan_d;
  logic             fold_nan;
`endif

  bf16_t            sum;
  bf16_t            fold_acc, fold_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_hs, out_hs;

  bf16_add u_add (
    .a_i (acc_q),
    .b_i (x_q),
    .y_o (sum)
  );

  // Hold off while the frame's last operand is pending or its result is unconsumed.
  assign in_ready_o  = rdy_en_q & ~(x_vld_q & x_last_q) & ~out_valid_q;
  assign in_hs       = in_valid_i & in_ready_o;
  assign out_hs      = out_valid_q & out_ready_i;
  assign out_valid_o = out_valid_q;
  assign s_o         = res_q.s;
  assign e_o         = res_q.e;
  assign m_o         = res_q.m;
  assign cnt_o       = res_cnt_q;
  assign rdy_en_d    = 1'b1;

  // Next-state: capture operand, fold the previous one, publish and clear at frame end.
  always_comb begin
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef BF16_ACC_NAN_STICKY_EN
    fold_nan = nan_q | bf16_is_nan(sum);
    fold_acc = nan_q ? acc_q : sum;
    fold_res = fold_nan ? bf16_t'(BF16_QNAN) : sum;
    nan_d    = nan_q;
`else
    fold_acc = sum;
    fold_res = sum;
`endif
    x_vld_d     = in_hs;
    x_d         = in_hs ? bf16_t'{s: s_i, e: e_i, m: m_i} : x_q;
    x_last_d    = in_hs ? in_last_i : x_last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    out_valid_d = out_hs ? 1'b0 : out_valid_q;
    if (x_vld_q) begin
      acc_d = fold_acc;
      cnt_d = cnt_inc;
`ifdef BF16_ACC_NAN_STICKY_EN
      nan_d = fold_nan;
`endif
      if (x_last_q) begin
        res_d       = fold_res;
        res_cnt_d   = cnt_inc;
        out_valid_d = 1'b1;
        acc_d       = bf16_t'(BF16_POS_ZERO);
        cnt_d       = '0;
`ifdef BF16_ACC_NAN_STICKY_EN
        nan_d       = 1'b0;
`endif
      end
    end
  end

  // State registers; reset empties the pipeline and discards any partial sum.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_q         <= bf16_t'(BF16_POS_ZERO);
      x_last_q    <= 1'b0;
      x_vld_q     <= 1'b0;
      acc_q       <= bf16_t'(BF16_POS_ZERO);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= bf16_t'(BF16_POS_ZERO);
      res_cnt_q   <= '0;
      rdy_en_q    <= 1'b0;
`ifdef BF16_ACC_NAN_STICKY_EN
      nan_q       <= 1'b0;
`endif
    end else begin
      x_q         <= x_d;
      x_last_q    <= x_last_d;
      x_vld_q     <= x_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      rdy_en_q    <= rdy_en_d;
`ifdef BF16_ACC_NAN_STICKY_EN
      nan_q       <= nan_d;
`endif
    end
  end

endmodule

// File: tb/tb_bf16_acc.sv
// tb/tb_bf16_acc.sv - scoreboard bench for bf16_acc with a real-arithmetic reference model
module tb_bf16_acc;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             nreset;
  logic             in_valid_i, in_ready_o, in_last_i;
  logic             s_i;
  logic [7:0]       e_i;
  logic [6:0]       m_i;
  logic             out_valid_o, out_ready_i;
  logic             s_o;
  logic [7:0]       e_o;
  logic [6:0]       m_o;
  logic [CNT_W-1:0] cnt_o;

  logic             bp_en = 1'b0, bp_bit = 1'b1, ready_ctl = 1'b1;
  int               n_cmp = 0, n_err = 0;
  logic [23:0]      exp_q[$];
  logic [15:0]      fq[$];

  assign out_ready_i = bp_en ? bp_bit : ready_ctl;

  bf16_acc #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .s_i         (s_i),
    .e_i         (e_i),
    .m_i         (m_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .e_o         (e_o),
    .m_o         (m_o),
    .cnt_o       (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model: values as reals, IEEE rules ----------------
  function automatic real to_real(input logic [15:0] v);
    real mag;
    int  ex;
    ex = int'(v[14:7]);
    if (ex == 0) mag = real'(int'(v[6:0])) * 2.0 ** (-133);
    else         mag = (1.0 + real'(int'(v[6:0])) / 128.0) * 2.0 ** (ex - 127);
    return v[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] from_real(input real r);
    logic sgn;
    real  a, n, fr;
    int   ex, ee, i;
    sgn = (r < 0.0);
    a   = sgn ? -r : r;
    ex  = 0;
    while (a >= 2.0 ** (ex + 1)) ex++;
    while (a < 2.0 ** ex) ex--;
    ee = (ex < -126) ? -126 : ex;
    n  = a / (2.0 ** (ee - 7));
    i  = $rtoi(n);
    fr = n - real'(i);
    if (fr > 0.5 || (fr == 0.5 && (i % 2) == 1)) i++;
    if (i >= 256) begin
      i  = 128;
      ee = ee + 1;
    end
    if (ee + 127 >= 255) return {sgn, 8'hFF, 7'h00};
    if (i >= 128) return {sgn, 8'(ee + 127), 7'(i - 128)};
    return {sgn, 8'h00, 7'(i)};
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    logic an, bn, ai, bi;
    real  r;
    an = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    bn = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    ai = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    bi = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7FC0;
    if (ai) return a;
    if (bi) return b;
    r = to_real(a) + to_real(b);
    if (r == 0.0) return {a[15] & b[15], 15'h0000};
    return from_real(r);
  endfunction

  function automatic logic [23:0] model_frame();
    logic [15:0] acc;
    int          n;
    acc = 16'h0000;
    foreach (fq[i]) acc = m_add(acc, fq[i]);
    n = fq.size();
    return {acc, 8'((n > 255) ? 255 : n)};
  endfunction

  function automatic logic [15:0] rand_op();
    int         k;
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
    k = $urandom_range(0, 79);
    s = 1'($urandom_range(0, 1));
    m = 7'($urandom_range(0, 127));
    if (k == 0) begin e = 8'hFF; m = m | 7'h01; end
    else if (k == 1) begin e = 8'hFF; m = 7'h00; end
    else if (k < 6) begin e = 8'h00; m = 7'h00; end
    else if (k < 10) e = 8'h00;
    else if (k < 16) e = 8'($urandom_range(1, 4));
    else if (k < 19) e = 8'($urandom_range(250, 254));
    else if (k < 26) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(122, 132));
    return {s, e, m};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_op(input logic [15:0] v, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    {s_i, e_i, m_i} = v;
    in_last_i = last;
    while (!in_ready_o && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready_o) chk("in_ready_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_frame(input bit use_model, input logic [23:0] expv, input bit gaps);
    exp_q.push_back(use_model ? model_frame() : expv);
    foreach (fq[i]) begin
      send_op(fq[i], i == fq.size() - 1);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid_o && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!out_valid_o) chk("out_valid_timeout", 32'(out_valid_o), 32'd1);
  endtask

  initial begin
    nreset = 1'b0;
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    {s_i, e_i, m_i} = 16'h0000;

    fork
      begin : monitor
        logic        stall;
        logic [23:0] held, e;
        stall = 1'b0;
        held  = '0;
        forever begin
          @(negedge clk);
          if (!nreset) stall = 1'b0;
          else begin
            if (stall) chk("hold_stable", 32'({out_valid_o, s_o, e_o, m_o, cnt_o}), 32'({1'b1, held}));
            if (out_valid_o && out_ready_i) begin
              if (exp_q.size() == 0) chk("unexpected_result", 32'(out_valid_o), 32'd0);
              else begin
                e = exp_q.pop_front();
                chk("result", 32'({s_o, e_o, m_o}), 32'(e[23:8]));
                chk("count", 32'(cnt_o), 32'(e[7:0]));
              end
            end
            stall = out_valid_o && !out_ready_i;
            held  = {s_o, e_o, m_o, cnt_o};
          end
        end
      end
      begin : backpressure
        forever begin
          @(posedge clk);
          #2;
          bp_bit = ($urandom_range(0, 3) != 0);
        end
      end
    join_none

    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_data", 32'({s_o, e_o, m_o}), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_edges", 32'(in_ready_o), 32'd0);
    nreset = 1'b1;
    #1;
    chk("release_ready_before_edge", 32'(in_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("release_ready_after_edge", 32'(in_ready_o), 32'd1);

    // back-to-back frame with latency check
    exp_q.push_back({16'h4060, 8'd3});
    send_op(16'h3F80, 1'b0);
    send_op(16'h4000, 1'b0);
    send_op(16'h3F00, 1'b1);
    chk("latency_not_yet", 32'(out_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(out_valid_o), 32'd1);
    chk("latency_data", 32'({s_o, e_o, m_o}), 32'h4060);
    wait_drain();

    fq = '{16'h3F80, 16'hBF80}; send_frame(1'b0, {16'h0000, 8'd2}, 1'b0);
    fq = '{16'h8000};           send_frame(1'b0, {16'h0000, 8'd1}, 1'b0);
    fq = '{16'h8000, 16'h8000}; send_frame(1'b0, {16'h0000, 8'd2}, 1'b0);
    wait_drain();

    // output held under back-pressure
    ready_ctl = 1'b0;
    exp_q.push_back({16'hC000, 8'd1});
    send_op(16'hC000, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_data", 32'({s_o, e_o, m_o}), 32'hC000);
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_ctl = 1'b1;
    @(posedge clk);
    #1;
    chk("consumed_valid", 32'(out_valid_o), 32'd0);
    chk("consumed_in_ready", 32'(in_ready_o), 32'd1);

    // gapped valid inside a frame
    exp_q.push_back({16'h4000, 8'd2});
    send_op(16'h3F80, 1'b0);
    repeat (3) @(posedge clk);
    send_op(16'h3F80, 1'b1);
    wait_drain();

    // reset in the middle of a frame
    send_op(16'h3F80, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    nreset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready_o), 32'd0);
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_data", 32'({s_o, e_o, m_o, cnt_o}), 32'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    fq = '{16'h3F80}; send_frame(1'b0, {16'h3F80, 8'd1}, 1'b0);

    fq = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
    send_frame(1'b0, {16'h40A0, 8'd5}, 1'b0);
    fq = '{16'h3F80, 16'h7FC1, 16'h3F80}; send_frame(1'b0, {16'h7FC0, 8'd3}, 1'b0);
    fq.delete();
    for (int i = 0; i < 300; i++) fq.push_back(16'h3F80);
    send_frame(1'b0, {16'h4380, 8'd255}, 1'b0);
    wait_drain();

    // randomized frames against the model, with gaps and random back-pressure
    bp_en = 1'b1;
    for (int f = 0; f < 80; f++) begin
      fq.delete();
      repeat ($urandom_range(1, 8)) fq.push_back(rand_op());
      send_frame(1'b1, 24'h0, 1'b1);
    end
    wait_drain();
    bp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
